// File: rtl/sram_1rw1r_clr.sv
// Behavioural SRAM: one read/write port, one read-only port, with
// per-lane write masks, 1- or 2-cycle read latency, optional write-to-read
// forwarding and a post-reset clear sequencer that zeroes every entry.
// Ports: clk/rst (sync, active high), ready (clear done);
//   port 0: csb0, web0, wmask0, addr0, din0 -> dout0, rvalid0
//   port 1: csb1, addr1 -> dout1, rvalid1
module sram_1rw1r_clr #(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 4,
  parameter int MASK_GRAN    = 8,
  parameter int READ_LATENCY = 1,
  parameter int FORWARD      = 1,
  localparam int RAM_DEPTH   = 2**ADDR_WIDTH,
  localparam int NUM_WMASKS  = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  rvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  rvalid1
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  ready_q;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  run;
  logic                  wr0;
  logic                  rd0;
  logic                  rd1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;

  // Requests are ignored entirely until the clear sequence finishes.
  assign run = (state_q == RUN);
  assign wr0 = run & ~csb0 & ~web0;
  assign rd0 = run & ~csb0 & web0;
  assign rd1 = run & ~csb1;

  // Merged word for a masked write: new lanes over the current contents.
  always_comb begin
    wdata0 = mem[addr0];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wmask0[i]) begin
        wdata0[i*MASK_GRAN +: MASK_GRAN] = din0[i*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  assign rdata0 = mem[addr0];

  // On a same-address collision the merged word equals what mem will hold
  // after this edge, so forwarding it gives the post-write view.
  always_comb begin
    rdata1 = mem[addr1];
    if ((FORWARD != 0) && wr0 && (addr0 == addr1)) begin
      rdata1 = wdata0;
    end
  end

  // Clear sequencer: walks every index once, then hands over to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == '1) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= CLEAR;
          idx_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: clear writes and port-0 writes are mutually exclusive
  // because writes are only accepted in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem[idx_q] <= '0;
      end else if (wr0) begin
        mem[addr0] <= wdata0;
      end
    end
  end

  // Launch signals into the output registers, optionally delayed by one
  // extra pipeline stage.
  logic                  lv0;
  logic                  lv1;
  logic [DATA_WIDTH-1:0] ld0;
  logic [DATA_WIDTH-1:0] ld1;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  pv0_q;
      logic                  pv1_q;
      logic [DATA_WIDTH-1:0] pd0_q;
      logic [DATA_WIDTH-1:0] pd1_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          pv0_q <= 1'b0;
          pv1_q <= 1'b0;
          pd0_q <= '0;
          pd1_q <= '0;
        end else begin
          pv0_q <= rd0;
          pv1_q <= rd1;
          if (rd0) pd0_q <= rdata0;
          if (rd1) pd1_q <= rdata1;
        end
      end

      assign lv0 = pv0_q;
      assign lv1 = pv1_q;
      assign ld0 = pd0_q;
      assign ld1 = pd1_q;
    end else begin : g_lat1
      assign lv0 = rd0;
      assign lv1 = rd1;
      assign ld0 = rdata0;
      assign ld1 = rdata1;
    end
  endgenerate

  logic [DATA_WIDTH-1:0] dout0_q;
  logic [DATA_WIDTH-1:0] dout1_q;
  logic                  rvalid0_q;
  logic                  rvalid1_q;

  // Output registers hold their value until the next completed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout0_q   <= '0;
      dout1_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= lv0;
      rvalid1_q <= lv1;
      if (lv0) dout0_q <= ld0;
      if (lv1) dout1_q <= ld1;
    end
  end

  assign ready   = ready_q;
  assign dout0   = dout0_q;
  assign dout1   = dout1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_sram_1rw1r_clr.sv
// Directed bench for sram_1rw1r_clr: two instances share stimulus,
// A = latency 1 with forwarding, B = latency 2 without forwarding.
module tb_sram_1rw1r_clr;

  localparam int DW = 256;
  localparam int AW = 4;
  localparam int NM = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          csb0, web0, csb1;
  logic [NM-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;

  logic          ready_a, rv0_a, rv1_a;
  logic [DW-1:0] do0_a, do1_a;
  logic          ready_b, rv0_b, rv1_b;
  logic [DW-1:0] do0_b, do1_b;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sram_1rw1r_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_GRAN(8),
    .READ_LATENCY(1), .FORWARD(1)
  ) u_a (
    .clk(clk), .rst(rst), .ready(ready_a),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(do0_a), .rvalid0(rv0_a),
    .csb1(csb1), .addr1(addr1), .dout1(do1_a), .rvalid1(rv1_a)
  );

  sram_1rw1r_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_GRAN(8),
    .READ_LATENCY(2), .FORWARD(0)
  ) u_b (
    .clk(clk), .rst(rst), .ready(ready_b),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(do0_b), .rvalid0(rv0_b),
    .csb1(csb1), .addr1(addr1), .dout1(do1_b), .rvalid1(rv1_b)
  );

  function automatic logic [DW-1:0] rep8(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NM-1:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    tick();
    idle();
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    idle();
    tick();
    tick();
    ncmp++;
    if ({ready_a, rv0_a, rv1_a} !== 3'b000) begin
      $display("FAIL reset_flags_a got %b want 000", {ready_a, rv0_a, rv1_a});
      nerr++;
    end
    ncmp++;
    if ({do0_a, do1_a} !== '0) begin
      $display("FAIL reset_dout_a got %h / %h want 0", do0_a, do1_a);
      nerr++;
    end
    ncmp++;
    if ({ready_b, rv0_b, rv1_b} !== 3'b000) begin
      $display("FAIL reset_flags_b got %b want 000", {ready_b, rv0_b, rv1_b});
      nerr++;
    end
    rst = 1'b0;
    n = 0;
    while (!ready_a && n < 40) begin
      tick();
      n++;
    end
    ncmp++;
    if (n !== 16) begin
      $display("FAIL clear_cycles got %0d want 16", n);
      nerr++;
    end
    ncmp++;
    if (ready_b !== 1'b1) begin
      $display("FAIL ready_b got %b want 1", ready_b);
      nerr++;
    end
  endtask

  task automatic test_clear_reads();
    for (int i = 0; i < 16; i++) begin
      csb1 = 1'b0;
      addr1 = AW'(i);
      tick();
      ncmp++;
      if ({rv1_a, do1_a} !== {1'b1, {DW{1'b0}}}) begin
        $display("FAIL clear_read[%0d] got rv=%b %h want rv=1 0", i, rv1_a, do1_a);
        nerr++;
      end
    end
    idle();
    tick();
    ncmp++;
    if (rv1_a !== 1'b0) begin
      $display("FAIL clear_rv1_drop got %b want 0", rv1_a);
      nerr++;
    end
  endtask

  task automatic test_masked_write();
    logic [DW-1:0] exp;
    exp = '0;
    exp[31:0] = 32'hAAAA_AAAA;
    do_write(4'd3, rep8(8'hAA), 32'h0000_000F);
    ncmp++;
    if (rv0_a !== 1'b0) begin
      $display("FAIL write_rv0 got %b want 0", rv0_a);
      nerr++;
    end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3;
    csb1 = 1'b0; addr1 = 4'd3;
    tick();
    idle();
    ncmp++;
    if ({rv0_a, do0_a} !== {1'b1, exp}) begin
      $display("FAIL mask_p0_a got rv=%b %h want rv=1 %h", rv0_a, do0_a, exp);
      nerr++;
    end
    ncmp++;
    if ({rv1_a, do1_a} !== {1'b1, exp}) begin
      $display("FAIL mask_p1_a got rv=%b %h want rv=1 %h", rv1_a, do1_a, exp);
      nerr++;
    end
    ncmp++;
    if (rv0_b !== 1'b0) begin
      $display("FAIL mask_lat2_early got %b want 0", rv0_b);
      nerr++;
    end
    tick();
    ncmp++;
    if ({rv0_b, do0_b, rv1_b, do1_b} !== {1'b1, exp, 1'b1, exp}) begin
      $display("FAIL mask_b got %b %h %b %h want 1 %h", rv0_b, do0_b, rv1_b, do1_b, exp);
      nerr++;
    end
  endtask

  task automatic test_forward();
    logic [DW-1:0] merged;
    merged = {8'hFF, {31{8'h11}}};
    do_write(4'd5, rep8(8'h11), '1);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd5;
    din0 = rep8(8'hFF); wmask0 = 32'h8000_0000;
    csb1 = 1'b0; addr1 = 4'd5;
    tick();
    idle();
    ncmp++;
    if ({rv1_a, do1_a} !== {1'b1, merged}) begin
      $display("FAIL fwd1_dout1 got rv=%b %h want rv=1 %h", rv1_a, do1_a, merged);
      nerr++;
    end
    ncmp++;
    if (rv0_a !== 1'b0) begin
      $display("FAIL fwd1_rv0 got %b want 0", rv0_a);
      nerr++;
    end
    tick();
    ncmp++;
    if ({rv1_b, do1_b} !== {1'b1, rep8(8'h11)}) begin
      $display("FAIL fwd0_dout1 got rv=%b %h want rv=1 %h", rv1_b, do1_b, rep8(8'h11));
      nerr++;
    end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd5;
    tick();
    idle();
    ncmp++;
    if (do0_a !== merged) begin
      $display("FAIL fwd_mem got %h want %h", do0_a, merged);
      nerr++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_write(4'd1, DW'(1), '1);
    do_write(4'd2, DW'(2), '1);
    do_write(4'd3, DW'(3), '1);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd1;
    tick();
    addr0 = 4'd2;
    ncmp++;
    if ({rv0_a, do0_a, rv0_b} !== {1'b1, DW'(1), 1'b0}) begin
      $display("FAIL b2b_c0 got %b %h %b want 1 1 0", rv0_a, do0_a, rv0_b);
      nerr++;
    end
    tick();
    addr0 = 4'd3;
    ncmp++;
    if ({rv0_a, do0_a, rv0_b, do0_b} !== {1'b1, DW'(2), 1'b1, DW'(1)}) begin
      $display("FAIL b2b_c1 got %b %h %b %h want 1 2 1 1", rv0_a, do0_a, rv0_b, do0_b);
      nerr++;
    end
    tick();
    idle();
    ncmp++;
    if ({rv0_a, do0_a, rv0_b, do0_b} !== {1'b1, DW'(3), 1'b1, DW'(2)}) begin
      $display("FAIL b2b_c2 got %b %h %b %h want 1 3 1 2", rv0_a, do0_a, rv0_b, do0_b);
      nerr++;
    end
    tick();
    ncmp++;
    if ({rv0_a, do0_a, rv0_b, do0_b} !== {1'b0, DW'(3), 1'b1, DW'(3)}) begin
      $display("FAIL b2b_c3 got %b %h %b %h want 0 3 1 3", rv0_a, do0_a, rv0_b, do0_b);
      nerr++;
    end
    tick();
    ncmp++;
    if ({rv0_b, do0_b} !== {1'b0, DW'(3)}) begin
      $display("FAIL b2b_hold got %b %h want 0 3", rv0_b, do0_b);
      nerr++;
    end
  endtask

  task automatic test_read_before_write();
    logic [DW-1:0] old;
    old = {8'hFF, {31{8'h11}}};
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd5;
    tick();
    ncmp++;
    if (do0_a !== old) begin
      $display("FAIL rbw_read got %h want %h", do0_a, old);
      nerr++;
    end
    web0 = 1'b0; din0 = rep8(8'h33); wmask0 = '1;
    tick();
    idle();
    ncmp++;
    if ({rv0_a, do0_a, rv0_b, do0_b} !== {1'b0, old, 1'b1, old}) begin
      $display("FAIL rbw_old got %b %h %b %h want 0 old 1 old", rv0_a, do0_a, rv0_b, do0_b);
      nerr++;
    end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd5;
    tick();
    idle();
    ncmp++;
    if (do0_a !== rep8(8'h33)) begin
      $display("FAIL rbw_new got %h want %h", do0_a, rep8(8'h33));
      nerr++;
    end
    tick();
  endtask

  task automatic req_during_clear();
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd0; din0 = '1; wmask0 = '1;
    csb1 = 1'b0; addr1 = 4'd0;
  endtask

  task automatic test_reset_mid_clear();
    int n;
    do_write(4'd9, rep8(8'h5A), '1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_during_clear();
    for (int i = 0; i < 7; i++) begin
      tick();
      ncmp++;
      if ({ready_a, rv0_a, rv1_a, rv0_b, rv1_b} !== 5'b0) begin
        $display("FAIL midclr[%0d] got %b want 00000", i,
                 {ready_a, rv0_a, rv1_a, rv0_b, rv1_b});
        nerr++;
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (!ready_a && n < 40) begin
      tick();
      n++;
      ncmp++;
      if ({rv0_a, rv1_a, rv0_b, rv1_b} !== 4'b0) begin
        $display("FAIL clr_req_rv got %b want 0000", {rv0_a, rv1_a, rv0_b, rv1_b});
        nerr++;
      end
    end
    idle();
    ncmp++;
    if (n !== 16) begin
      $display("FAIL reclear_cycles got %0d want 16", n);
      nerr++;
    end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd9;
    csb1 = 1'b0; addr1 = 4'd0;
    tick();
    idle();
    ncmp++;
    if ({rv0_a, do0_a, rv1_a, do1_a} !== {1'b1, {DW{1'b0}}, 1'b1, {DW{1'b0}}}) begin
      $display("FAIL post_clr_a got %b %h %b %h want 1 0 1 0", rv0_a, do0_a, rv1_a, do1_a);
      nerr++;
    end
    tick();
    ncmp++;
    if ({rv0_b, do0_b, rv1_b, do1_b} !== {1'b1, {DW{1'b0}}, 1'b1, {DW{1'b0}}}) begin
      $display("FAIL post_clr_b got %b %h %b %h want 1 0 1 0", rv0_b, do0_b, rv1_b, do1_b);
      nerr++;
    end
  endtask

  initial begin
    test_reset();
    test_clear_reads();
    test_masked_write();
    test_forward();
    test_back_to_back();
    test_read_before_write();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
